// File: rtl/sevenseg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sevenseg_scan                                                              |
// | Four-digit multiplexed seven-segment driver with frame-aligned digit       |
// | double buffering and per-digit blink. Optional dp: SEVSEG_DP_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sevenseg_scan #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] blank_mask,
    input  logic       blink_en,
`ifdef SEVSEG_DP_EN
    input  logic [3:0] dp,
`endif
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame_done
);

    localparam int                c_PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                c_BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(SCAN_DIV - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(BLINK_DIV - 1);

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic                r_blink_phase;
    logic [1:0]          r_idx;
    logic [3:0][3:0]     r_act;
    logic [3:0][3:0]     r_pend;
    logic                r_pend_v;
    logic [3:0]          r_an;
    logic [7:0]          r_seg;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_boundary;
    logic [3:0][3:0]     w_d;
    logic [3:0][3:0]     w_next_act;
    logic [1:0]          w_next_idx;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [6:0]          w_seg_hi;
    logic [6:0]          w_seg7_n;
    logic                w_dp_n;

    assign w_tick     = (r_pcnt == c_PCNT_LAST);
    assign w_boundary = w_tick && (r_idx == 2'd3);
    assign w_d        = {d3, d2, d1, d0};
    assign w_next_idx = r_idx + 2'd1;

    // A load landing on the boundary bypasses the pending buffer entirely.
    assign w_next_act = !w_boundary ? r_act :
                        load        ? w_d   :
                        r_pend_v    ? r_pend : r_act;

    assign w_digit = w_next_act[w_next_idx];
    assign w_blank = blink_en & r_blink_phase & blank_mask[w_next_idx];

    always_comb begin
        w_seg_hi = 7'b0000000;
        case (w_digit)
            4'd0:    w_seg_hi = 7'b1111110;
            4'd1:    w_seg_hi = 7'b0110000;
            4'd2:    w_seg_hi = 7'b1101101;
            4'd3:    w_seg_hi = 7'b1111001;
            4'd4:    w_seg_hi = 7'b0110011;
            4'd5:    w_seg_hi = 7'b1011011;
            4'd6:    w_seg_hi = 7'b1011111;
            4'd7:    w_seg_hi = 7'b1110000;
            4'd8:    w_seg_hi = 7'b1111111;
            4'd9:    w_seg_hi = 7'b1111011;
            default: w_seg_hi = 7'b0000000;
        endcase
    end

    assign w_seg7_n = w_blank ? 7'h7F : ~w_seg_hi;

`ifdef SEVSEG_DP_EN
    logic [3:0] r_act_dp;
    logic [3:0] r_pend_dp;
    logic [3:0] w_next_act_dp;

    assign w_next_act_dp = !w_boundary ? r_act_dp :
                           load        ? dp       :
                           r_pend_v    ? r_pend_dp : r_act_dp;
    assign w_dp_n = w_blank | ~w_next_act_dp[w_next_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_dp  <= 4'h0;
            r_pend_dp <= 4'h0;
        end else begin
            r_act_dp <= w_next_act_dp;
            if (load) r_pend_dp <= dp;
        end
    end
`else
    assign w_dp_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt        <= '0;
            r_bcnt        <= '0;
            r_blink_phase <= 1'b0;
            r_idx         <= 2'd3;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) r_idx <= w_next_idx;
            if (r_bcnt == c_BCNT_LAST) begin
                r_bcnt        <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act    <= '1;
            r_pend   <= '1;
            r_pend_v <= 1'b0;
        end else begin
            r_act <= w_next_act;
            if (load) r_pend <= w_d;
            if (w_boundary)  r_pend_v <= 1'b0;
            else if (load)   r_pend_v <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= 4'b1111;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_tick) begin
                r_an  <= ~(4'b0001 << w_next_idx);
                r_seg <= {w_seg7_n, w_dp_n};
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
